// File: rtl/read_master.sv
`timescale 1ns/1ps
// DMA read-side master: streams Length bytes of Avalon-MM word reads into the
// shared data FIFO, throttled by outstanding-read and FIFO-space limits.
module read_master #(
  parameter int MAX_PENDING = 4,
  parameter int FIFO_DEPTH  = 256,
  parameter int USEDW_WIDTH = 8
) (
  input  logic                   iClk,
  input  logic                   iReset_n,
  input  logic                   Start,
  input  logic [31:0]            Length,
  input  logic [31:0]            RM_startaddress,
  input  logic                   FF_full,
  input  logic [USEDW_WIDTH-1:0] FF_usedw,
  output logic                   FF_writerequest,
  output logic [31:0]            FF_data,
  output logic                   oRM_read,
  output logic [31:0]            oRM_readaddress,
  input  logic [31:0]            iRM_readdata,
  input  logic                   iRM_waitrequest,
  input  logic                   iRM_readdatavalid,
  output logic                   RM_done,
  output logic [1:0]             state_dbg
);

  // Avalon handshake: a read is accepted when oRM_read=1 and
  // iRM_waitrequest=0; while stalled, oRM_read and oRM_readaddress hold.
  // Each iRM_readdatavalid beat during READ/DRAIN is pushed one cycle later.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SW = USEDW_WIDTH + 2;

  state_t      state;
  logic [29:0] total;
  logic [29:0] issued;
  logic [29:0] returned;

  logic          active;
  logic          accept;
  logic          beat;
  logic [29:0]   issued_n;
  logic [29:0]   returned_n;
  logic [3:0]    pending_n;
  logic [SW-1:0] fill_need;
  logic          can_issue_n;
  logic          unused_len;

  assign unused_len = ^Length[1:0];
  assign state_dbg  = state;

  assign active     = (state == READ) || (state == DRAIN);
  assign accept     = oRM_read && !iRM_waitrequest;
  assign beat       = iRM_readdatavalid && active;
  assign issued_n   = issued + {29'd0, accept};
  assign returned_n = returned + {29'd0, beat};
  assign pending_n  = 4'(issued_n - returned_n);

  // Issue decision for the next cycle uses the counts after this edge. The
  // current push is counted too because FF_usedw reflects it only a cycle late.
  assign fill_need = SW'(FF_usedw) + SW'(pending_n) + SW'(beat)
                   + SW'(FF_writerequest) + SW'(1);
  assign can_issue_n = (issued_n < total) && !FF_full
                    && (pending_n < 4'(MAX_PENDING))
                    && (fill_need <= SW'(FIFO_DEPTH - 1));

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state           <= IDLE;
      total           <= '0;
      issued          <= '0;
      returned        <= '0;
      FF_writerequest <= 1'b0;
      FF_data         <= '0;
      oRM_read        <= 1'b0;
      oRM_readaddress <= '0;
      RM_done         <= 1'b0;
    end else begin
      FF_writerequest <= beat;
      if (beat) FF_data <= iRM_readdata;

      case (state)
        IDLE: begin
          RM_done  <= 1'b0;
          oRM_read <= 1'b0;
          if (Start) begin
            oRM_readaddress <= RM_startaddress;
            total           <= Length[31:2];
            issued          <= '0;
            returned        <= '0;
            if (Length[31:2] != 30'd0) begin
              state <= READ;
            end else begin
              state   <= DONE;
              RM_done <= 1'b1;
            end
          end
        end

        READ: begin
          issued   <= issued_n;
          returned <= returned_n;
          if (accept) oRM_readaddress <= oRM_readaddress + 32'd4;
          if (accept && (issued_n == total)) begin
            state    <= DRAIN;
            oRM_read <= 1'b0;
          end else if (!(oRM_read && iRM_waitrequest)) begin
            oRM_read <= can_issue_n;
          end
        end

        DRAIN: begin
          returned <= returned_n;
          oRM_read <= 1'b0;
          // Done once the final word's push cycle has passed.
          if ((returned_n == total) && !beat) begin
            state   <= DONE;
            RM_done <= 1'b1;
          end
        end

        DONE: begin
          RM_done  <= 1'b1;
          oRM_read <= 1'b0;
          if (!Start) begin
            state   <= IDLE;
            RM_done <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_master.sv
`timescale 1ns/1ps
// Bench for read_master: Avalon slave responder with stall/latency/hold
// control, and a scoreboard of expected read addresses and pushed words.
module tb_read_master;

  logic        iClk;
  logic        iReset_n;
  logic        Start;
  logic [31:0] Length;
  logic [31:0] RM_startaddress;
  logic        FF_full;
  logic [7:0]  FF_usedw;
  logic        FF_writerequest;
  logic [31:0] FF_data;
  logic        oRM_read;
  logic [31:0] oRM_readaddress;
  logic [31:0] iRM_readdata;
  logic        iRM_waitrequest;
  logic        iRM_readdatavalid;
  logic        RM_done;
  logic [1:0]  state_dbg;

  read_master #(.MAX_PENDING(4), .FIFO_DEPTH(256), .USEDW_WIDTH(8)) dut (
    .iClk              (iClk),
    .iReset_n          (iReset_n),
    .Start             (Start),
    .Length            (Length),
    .RM_startaddress   (RM_startaddress),
    .FF_full           (FF_full),
    .FF_usedw          (FF_usedw),
    .FF_writerequest   (FF_writerequest),
    .FF_data           (FF_data),
    .oRM_read          (oRM_read),
    .oRM_readaddress   (oRM_readaddress),
    .iRM_readdata      (iRM_readdata),
    .iRM_waitrequest   (iRM_waitrequest),
    .iRM_readdatavalid (iRM_readdatavalid),
    .RM_done           (RM_done),
    .state_dbg         (state_dbg)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  ret_t        ret_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int words = 0;
  int acc_cnt = 0;
  int val_cnt = 0;
  int push_cnt = 0;
  int read_seen = 0;
  int max_out = 0;
  int lat = 2;
  int hold_until = 0;
  int stall_at = -1;
  int stall_len = 0;
  int stall_cnt = 0;
  int last_push_cyc = 0;
  int start_cyc = 0;
  logic        stall_active = 1'b0;
  logic [31:0] stall_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  // Avalon slave responder and FIFO-side monitor, evaluated mid-cycle.
  always @(negedge iClk) begin
    int out;
    logic [31:0] e;
    ret_t r;
    cyc++;
    if (FF_writerequest) begin
      push_cnt++;
      last_push_cyc = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("push_data", FF_data, e);
      end else begin
        check("push_count", 32'(push_cnt), 32'(words));
      end
    end
    if (oRM_read) read_seen++;
    if (stall_active) begin
      check("stall_read", 32'(oRM_read), 32'd1);
      check("stall_addr", oRM_readaddress, stall_addr);
    end
    if (oRM_read && acc_cnt == stall_at && stall_cnt < stall_len) begin
      iRM_waitrequest = 1'b1;
      if (stall_cnt == 0) stall_addr = oRM_readaddress;
      stall_cnt++;
      stall_active = 1'b1;
    end else begin
      iRM_waitrequest = 1'b0;
    end
    if (oRM_read && !iRM_waitrequest) begin
      acc_cnt++;
      stall_active = 1'b0;
      if (exp_addr_q.size() > 0) begin
        e = exp_addr_q.pop_front();
        check("rd_addr", oRM_readaddress, e);
      end else begin
        check("rd_count", 32'(acc_cnt), 32'(words));
      end
      r.due  = cyc + lat;
      r.data = data_of(oRM_readaddress);
      ret_q.push_back(r);
    end
    if (ret_q.size() > 0 && cyc >= hold_until && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      iRM_readdatavalid = 1'b1;
      iRM_readdata      = r.data;
      val_cnt++;
    end else begin
      iRM_readdatavalid = 1'b0;
      iRM_readdata      = $urandom;
    end
    out = acc_cnt - val_cnt;
    if (out > max_out) max_out = out;
  end

  // driver tasks
  task automatic tick();
    @(negedge iClk);
    #1;
  endtask

  task automatic begin_xfer(input logic [31:0] addr, input logic [31:0] len,
                            input int lat_i, input int hold_i,
                            input int st_at, input int st_len);
    exp_q.delete();
    exp_addr_q.delete();
    words = int'(len >> 2);
    for (int i = 0; i < words; i++) begin
      exp_addr_q.push_back(addr + 32'(4 * i));
      exp_q.push_back(data_of(addr + 32'(4 * i)));
    end
    acc_cnt = 0;
    val_cnt = 0;
    push_cnt = 0;
    read_seen = 0;
    max_out = 0;
    lat = lat_i;
    hold_until = cyc + hold_i;
    stall_at = st_at;
    stall_len = st_len;
    stall_cnt = 0;
    stall_active = 1'b0;
    RM_startaddress = addr;
    Length = len;
    Start = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic end_xfer();
    int t = 0;
    while (!RM_done && t < 3000) begin
      tick();
      t++;
    end
    if (!RM_done) begin
      check("done_timeout", 32'(t), 32'd0);
    end else if (words == 0) begin
      check("done_lat_empty", 32'(cyc - start_cyc), 32'd1);
    end else begin
      check("done_lat", 32'(cyc - last_push_cyc), 32'd1);
    end
    check("push_total", 32'(push_cnt), 32'(words));
    check("accept_total", 32'(acc_cnt), 32'(words));
    check("exp_left", 32'(exp_q.size()), 32'd0);
    Length = $urandom;
    RM_startaddress = $urandom;
    repeat (3) tick();
    check("done_hold", 32'(RM_done), 32'd1);
    check("no_retrigger", 32'(acc_cnt), 32'(words));
    Start = 1'b0;
    tick();
    check("done_clear", 32'(RM_done), 32'd0);
    check("state_idle", 32'(state_dbg), 32'd0);
  endtask

  initial begin
    int t;
    iReset_n = 1'b0;
    Start = 1'b0;
    Length = '0;
    RM_startaddress = '0;
    FF_full = 1'b0;
    FF_usedw = '0;
    iRM_readdata = '0;
    iRM_waitrequest = 1'b0;
    iRM_readdatavalid = 1'b0;
    repeat (3) tick();
    check("rst_wreq", 32'(FF_writerequest), 32'd0);
    check("rst_data", FF_data, 32'd0);
    check("rst_read", 32'(oRM_read), 32'd0);
    check("rst_addr", oRM_readaddress, 32'd0);
    check("rst_done", 32'(RM_done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    iReset_n = 1'b1;
    tick();

    // basic 4-word transfer
    begin_xfer(32'h0000_1000, 32'd16, 2, 0, -1, 0);
    end_xfer();

    // 3-cycle stall on the second read; Length[1:0] ignored
    begin_xfer(32'h0000_1000, 32'd18, 2, 0, 1, 3);
    end_xfer();
    check("stall_cycles", 32'(stall_cnt), 32'd3);

    // withheld data: outstanding reads capped at MAX_PENDING
    begin_xfer(32'h0000_4000, 32'd64, 1, 30, -1, 0);
    end_xfer();
    check("pend_max", 32'(max_out), 32'd4);

    // nearly full FIFO allows only three reads in flight
    FF_usedw = 8'd252;
    begin_xfer(32'h0000_8000, 32'd32, 2, 30, -1, 0);
    end_xfer();
    check("pend_fifo_max", 32'(max_out), 32'd3);
    FF_usedw = 8'd0;

    // FF_full blocks all issue
    FF_full = 1'b1;
    begin_xfer(32'h0000_9000, 32'd16, 1, 0, -1, 0);
    repeat (20) tick();
    check("full_block", 32'(read_seen), 32'd0);
    FF_full = 1'b0;
    end_xfer();

    // empty transfers
    begin_xfer(32'h0000_0000, 32'd0, 1, 0, -1, 0);
    end_xfer();
    check("len0_reads", 32'(read_seen), 32'd0);
    begin_xfer(32'h0000_0010, 32'd3, 1, 0, -1, 0);
    end_xfer();
    check("len3_reads", 32'(read_seen), 32'd0);

    // asynchronous reset in DRAIN with two reads outstanding
    begin_xfer(32'h0000_2000, 32'd8, 2, 1000, -1, 0);
    t = 0;
    while (acc_cnt < 2 && t < 100) begin
      tick();
      t++;
    end
    check("rst_setup_acc", 32'(acc_cnt), 32'd2);
    tick();
    check("rst_setup_drain", 32'(state_dbg), 32'd2);
    check("rst_setup_pend", 32'(acc_cnt - val_cnt), 32'd2);
    Start = 1'b0;
    #2 iReset_n = 1'b0;
    #1;
    check("arst_wreq", 32'(FF_writerequest), 32'd0);
    check("arst_data", FF_data, 32'd0);
    check("arst_read", 32'(oRM_read), 32'd0);
    check("arst_addr", oRM_readaddress, 32'd0);
    check("arst_done", 32'(RM_done), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    words = 0;
    push_cnt = 0;
    tick();
    iReset_n = 1'b1;
    hold_until = cyc;
    repeat (10) tick();
    check("late_valid_drained", 32'(ret_q.size()), 32'd0);
    check("late_valid_push", 32'(push_cnt), 32'd0);
    begin_xfer(32'h0000_3000, 32'd16, 3, 0, -1, 0);
    end_xfer();

    // address wrap with random latency
    begin_xfer(32'hFFFF_FFF8, 32'd16, int'($urandom_range(1, 4)), 0, -1, 0);
    end_xfer();

    // random mixed transfers
    for (int k = 0; k < 4; k++) begin
      begin_xfer({$urandom_range(0, 32'hFFFF), 16'h0000} | 32'(4 * $urandom_range(0, 255)),
                 32'($urandom_range(1, 80)), int'($urandom_range(1, 4)),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)));
      end_xfer();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/read_master.md
Name: read_master

Overview:
- DMA read-side master. Sits directly upstream of the write master and feeds it through the shared data FIFO.
- On Start, issues Avalon-MM word reads from RM_startaddress for Length bytes and pushes each returned word into the FIFO.
- Supports up to MAX_PENDING outstanding reads and never issues a read whose data the FIFO could not absorb.
- Signals completion on RM_done once every word has been pushed.

Parameters:
- MAX_PENDING, 4: maximum accepted-but-unreturned reads (1..15).
- FIFO_DEPTH, 256: word capacity of the downstream FIFO.
- USEDW_WIDTH, 8: width of FF_usedw. FIFO_DEPTH = 2**USEDW_WIDTH.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iReset_n  in  1  asynchronous active-low reset.
- Start  in  1  level; sampled only in IDLE.
- Length  in  32  transfer size in bytes; bits [1:0] ignored.
- RM_startaddress  in  32  first read byte address, word aligned.
- FF_full  in  1  FIFO full.
- FF_usedw  in  USEDW_WIDTH  FIFO fill level in words.
- FF_writerequest  out  1  FIFO push strobe.
- FF_data  out  32  FIFO write data.
- oRM_read  out  1  Avalon read request.
- oRM_readaddress  out  32  Avalon byte address.
- iRM_readdata  in  32  Avalon read data.
- iRM_waitrequest  in  1  Avalon stall.
- iRM_readdatavalid  in  1  Avalon read-data strobe.
- RM_done  out  1  transfer complete (level).

Behaviour:
- Reset values: FF_writerequest=0, FF_data=0, oRM_read=0, oRM_readaddress=0, RM_done=0, state=IDLE, all counters 0.
- Reset is asynchronous. Reset mid-transfer aborts immediately. Responses still outstanding on the bus are not tracked.
- Word counts: total = Length[31:2]. issued and returned are 30-bit counters. pending = issued - returned, 4 bits.
- in_flight = pending + FF_writerequest.
- can_issue = (issued < total) && !FF_full && (pending < MAX_PENDING) && (FF_usedw + in_flight + 1 <= FIFO_DEPTH - 1).
  - Evaluate the sum at USEDW_WIDTH+2 bits. No overflow.
- Avalon handshake:
  - A read is accepted in a cycle where oRM_read=1 and iRM_waitrequest=0. The acceptance increments issued and advances oRM_readaddress by 4; the new address is visible the next cycle.
  - While iRM_waitrequest=1, oRM_read and oRM_readaddress hold stable.
  - oRM_read may deassert only on an acceptance cycle or when can_issue is false with no request presented.
- Data path, one cycle latency:
  - FF_writerequest <= iRM_readdatavalid && (state is READ or DRAIN).
  - FF_data <= iRM_readdata when valid.
  - returned increments on each valid beat.
  - iRM_readdatavalid in IDLE or DONE is ignored: no push.
- Acceptance and readdatavalid in the same cycle: issued and returned both increment, so pending is unchanged.
- State machine:
  - IDLE: when Start=1, latch oRM_readaddress<=RM_startaddress and total<=Length[31:2], clear counters. Go to READ if Length[31:2]!=0, else DONE.
  - READ: oRM_read follows can_issue, subject to the hold rule above. Go to DRAIN on the acceptance cycle where issued+1 == total.
  - DRAIN: oRM_read=0. Go to DONE when returned == total and FF_writerequest has fallen to 0, i.e. the last word is pushed.
  - DONE: RM_done=1. Go to IDLE when Start=0.
  - IDLE: RM_done=0.
- Start held high after DONE does not retrigger; Start must drop, then rise again.
- Start changes outside IDLE are ignored. Length and RM_startaddress are latched in IDLE, so later changes have no effect.
- Address wraps modulo 2^32 with no error.

Test Plan:
1. RM_startaddress=0x1000, Length=16, zero waitrequest, readdatavalid 2 cycles after each accept -> reads to 0x1000, 0x1004, 0x1008, 0x100C; 4 pushes in order; RM_done=1 one cycle after the 4th push; RM_done=0 after Start drops.
2. Same transfer, waitrequest=1 for 3 cycles on the 2nd read -> address 0x1004 and oRM_read stable for all 3 stall cycles; exactly 4 accepts.
3. Length=64, readdatavalid withheld -> at most MAX_PENDING=4 accepts before the first data returns; issuing resumes as data returns; 16 words pushed in order.
4. FF_usedw=252, FIFO_DEPTH=256 -> at most 3 reads issued while usedw stays constant. FF_full=1 blocks all issue.
5. Length=0 and Length=3 -> no oRM_read; RM_done=1 on the cycle after Start; back to IDLE when Start=0.
6. Reset asserted mid-DRAIN with 2 pending -> all outputs 0 asynchronously. Late readdatavalid in IDLE -> no push. A new Start transfers correctly.
